load_store_unit: RTL and testbench

//  MEM-stage load/store unit between the EX/MEM pipeline register and the word-only Data_Memory.
//  - Loads: extracts and extends LB/LH/LW/LBU/LHU from the 32-bit read word.
//  - Stores: SW writes directly; SB/SH use a 2-cycle read-modify-write, stalling the pipeline.
//  - Misaligned accesses are blocked from memory and reported.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_byte_lane.sv | 43 ++++
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM encoding
// and the alignment rule applied to every request.
package lsu_pkg;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } lsu_state_e;

   // Reserved funct3 codes are reported exactly like misaligned accesses.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      case (funct3)
         FUNCT3_B, FUNCT3_BU: return 1'b0;
         FUNCT3_H, FUNCT3_HU: return offset[0];
         FUNCT3_W:            return (offset != 2'b00);
         default:             return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extraction/extension and sub-word store merging
// into the word most recently read from memory.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   input  logic [15:0] data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_word_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel    = word_i[{offset_i, 3'b000} +: 8];
      half_sel    = offset_i[1] ? word_i[31:16] : word_i[15:0];
      load_data_o = 32'd0;
      case (funct3_i)
         FUNCT3_B:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
         FUNCT3_H:  load_data_o = {{16{half_sel[15]}}, half_sel};
         FUNCT3_W:  load_data_o = word_i;
         FUNCT3_BU: load_data_o = {24'd0, byte_sel};
         FUNCT3_HU: load_data_o = {16'd0, half_sel};
         default:   load_data_o = 32'd0;
      endcase
   end

   // Each byte lane takes store data when the access covers it, otherwise keeps the old byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic hit;
         assign hit = ((funct3_i[1:0] == 2'b00) && (offset_i == 2'(gi))) ||
                      ((funct3_i[1:0] == 2'b01) && (offset_i[1] == (gi >= 2)));
         assign merge_word_o[8*gi +: 8] = hit ? (funct3_i[0] ? data_i[8*(gi%2) +: 8] : data_i[7:0])
                                              : word_i[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: zero-latency loads, single-cycle SW, two-cycle
// read-modify-write for SB/SH, and misaligned-access blocking/reporting.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_LSB   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Req_Valid_i,
   input  logic                  Is_Store_i,
   input  logic [2:0]            Funct3_i,
   input  logic [DATA_WIDTH-1:0] Address_i,
   input  logic [DATA_WIDTH-1:0] Store_Data_i,
   input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i,
   output logic                  Mem_Read_o,
   output logic                  Mem_Write_o,
   output logic [DATA_WIDTH-1:0] Mem_Address_o,
   output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
   output logic [DATA_WIDTH-1:0] Load_Data_o,
   output logic                  Stall_o,
   output logic                  Misaligned_o,
   output logic [DATA_WIDTH-1:0] Fault_Addr_o
);

   lsu_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] merge_q, merge_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] fault_addr_q, fault_addr_d;

   logic [ADDR_LSB-1:0]   offset;
   logic [DATA_WIDTH-1:0] word_addr;
   logic [DATA_WIDTH-1:0] lane_load;
   logic [DATA_WIDTH-1:0] lane_merge;
   logic                  req_idle, misaligned, access;
   logic                  sub_store, word_store, load;

   assign offset     = Address_i[ADDR_LSB-1:0];
   assign word_addr  = {Address_i[DATA_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
   assign req_idle   = Req_Valid_i && (state_q == IDLE);
   assign misaligned = req_idle && is_misaligned(Funct3_i, offset);
   assign access     = req_idle && !misaligned;
   // Once reserved codes are filtered out, funct3[1] alone separates W from B/H/BU/HU.
   assign sub_store  = access && Is_Store_i && !Funct3_i[1];
   assign word_store = access && Is_Store_i && Funct3_i[1];
   assign load       = access && !Is_Store_i;

   lsu_byte_lane u_byte_lane (
      .word_i       (Mem_Read_Data_i),
      .offset_i     (offset),
      .funct3_i     (Funct3_i),
      .data_i       (Store_Data_i[15:0]),
      .load_data_o  (lane_load),
      .merge_word_o (lane_merge)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sub_store) state_d = RMW_WR;
         RMW_WR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      merge_d      = sub_store ? lane_merge : merge_q;
      addr_d       = sub_store ? word_addr : addr_q;
      fault_addr_d = misaligned ? Address_i : fault_addr_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         merge_q      <= '0;
         addr_q       <= '0;
         fault_addr_q <= '0;
      end else begin
         merge_q      <= merge_d;
         addr_q       <= addr_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   // Outputs are gated by reset so an abandoned RMW write drops the instant reset asserts.
   always_comb begin
      Mem_Read_o       = 1'b0;
      Mem_Write_o      = 1'b0;
      Mem_Address_o    = '0;
      Mem_Write_Data_o = '0;
      Load_Data_o      = '0;
      Stall_o          = 1'b0;
      Misaligned_o     = 1'b0;
      if (reset) begin
         case (state_q)
            IDLE: begin
               Mem_Read_o       = load || sub_store;
               Mem_Write_o      = word_store;
               Mem_Address_o    = access ? word_addr : '0;
               Mem_Write_Data_o = word_store ? Store_Data_i : '0;
               Load_Data_o      = load ? lane_load : '0;
               Stall_o          = sub_store;
               Misaligned_o     = misaligned;
            end
            RMW_WR: begin
               Mem_Write_o      = 1'b1;
               Mem_Address_o    = addr_q;
               Mem_Write_Data_o = merge_q;
            end
            default: ;
         endcase
      end
   end

   assign Fault_Addr_o = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by random
// loads/stores checked against a word-array reference model of memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Req_Valid_i, Is_Store_i;
   logic [2:0]  Funct3_i;
   logic [31:0] Address_i, Store_Data_i, Mem_Read_Data_i;
   logic        Mem_Read_o, Mem_Write_o, Stall_o, Misaligned_o;
   logic [31:0] Mem_Address_o, Mem_Write_Data_o, Load_Data_o, Fault_Addr_o;

   logic [31:0] tb_mem  [256];
   logic [31:0] ref_mem [256];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk              (clk),
      .reset            (reset),
      .Req_Valid_i      (Req_Valid_i),
      .Is_Store_i       (Is_Store_i),
      .Funct3_i         (Funct3_i),
      .Address_i        (Address_i),
      .Store_Data_i     (Store_Data_i),
      .Mem_Read_Data_i  (Mem_Read_Data_i),
      .Mem_Read_o       (Mem_Read_o),
      .Mem_Write_o      (Mem_Write_o),
      .Mem_Address_o    (Mem_Address_o),
      .Mem_Write_Data_o (Mem_Write_Data_o),
      .Load_Data_o      (Load_Data_o),
      .Stall_o          (Stall_o),
      .Misaligned_o     (Misaligned_o),
      .Fault_Addr_o     (Fault_Addr_o)
   );

   // Bench-side Data_Memory: combinational read, write at the clock edge.
   assign Mem_Read_Data_i = tb_mem[Mem_Address_o[9:2]];
   always @(posedge clk) if (Mem_Write_o) tb_mem[Mem_Address_o[9:2]] <= Mem_Write_Data_o;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) return a[0];
      if (f3 == 3'd2) return (a[1:0] != 2'b00);
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input int off);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * off));
      h = 16'(w >> (8 * off));
      case (f3)
         3'd0:    return {{24{b[7]}}, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd2:    return w;
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] f3, input int off,
                                               input logic [31:0] d);
      logic [31:0] mask;
      mask = (f3 == 3'd0) ? (32'hFF << (8 * off)) : (32'hFFFF << (8 * off));
      return (w & ~mask) | ((d << (8 * off)) & mask);
   endfunction

   // Called just after a rising edge; returns just after the edge that retires the access.
   task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      logic        mis, sub, sw;
      logic [31:0] word;
      int          idx, off;
      idx  = int'(a[9:2]);
      off  = int'(a[1:0]);
      mis  = model_misaligned(f3, a);
      sub  = st && !mis && (f3 == 3'd0 || f3 == 3'd1);
      sw   = st && !mis && (f3 == 3'd2);
      word = ref_mem[idx];
      $display("op store=%0d f3=%0d addr=%h data=%h", st, f3, a, d);
      Req_Valid_i = 1'b1; Is_Store_i = st; Funct3_i = f3; Address_i = a; Store_Data_i = d;
      @(negedge clk);
      chk("misaligned", {31'd0, Misaligned_o}, {31'd0, mis});
      chk("stall", {31'd0, Stall_o}, {31'd0, sub});
      chk("mem_read", {31'd0, Mem_Read_o}, {31'd0, !mis && (!st || sub)});
      chk("mem_write", {31'd0, Mem_Write_o}, {31'd0, sw});
      chk("mem_addr", Mem_Address_o, mis ? 32'd0 : {a[31:2], 2'b00});
      chk("load_data", Load_Data_o, (st || mis) ? 32'd0 : model_load(word, f3, off));
      if (sw) chk("sw_data", Mem_Write_Data_o, d);
      @(posedge clk); #1;
      if (mis) chk("fault_addr", Fault_Addr_o, a);
      if (sw) ref_mem[idx] = d;
      if (sub) begin
         @(negedge clk);
         chk("rmw_write", {31'd0, Mem_Write_o}, 32'd1);
         chk("rmw_read", {31'd0, Mem_Read_o}, 32'd0);
         chk("rmw_stall", {31'd0, Stall_o}, 32'd0);
         chk("rmw_addr", Mem_Address_o, {a[31:2], 2'b00});
         chk("rmw_data", Mem_Write_Data_o, model_store(word, f3, off, d));
         ref_mem[idx] = model_store(word, f3, off, d);
         @(posedge clk); #1;
      end
      Req_Valid_i = 1'b0;
   endtask

   initial begin
      logic [2:0] st_f3 [7];
      logic [2:0] ld_f3 [7];
      int         bad;
      logic       st;
      logic [2:0] f3;
      st_f3 = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd7};
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = $urandom;
         tb_mem[i]  = ref_mem[i];
      end
      ref_mem[0] = 32'h0;       tb_mem[0] = 32'h0;
      ref_mem[4] = 32'h80FF_1234; tb_mem[4] = 32'h80FF_1234;
      ref_mem[8] = 32'h1122_3344; tb_mem[8] = 32'h1122_3344;

      // Reset with a valid aligned load presented: everything must stay quiet.
      reset = 1'b0;
      Req_Valid_i = 1'b1; Is_Store_i = 1'b0; Funct3_i = 3'd2; Address_i = 32'h10; Store_Data_i = 32'h0;
      #2;
      chk("rst_mem_read", {31'd0, Mem_Read_o}, 32'd0);
      chk("rst_load_data", Load_Data_o, 32'd0);
      chk("rst_mem_addr", Mem_Address_o, 32'd0);
      chk("rst_fault_addr", Fault_Addr_o, 32'd0);
      Req_Valid_i = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Reset during the write half of an SB abandons the write.
      $display("op reset during SB rmw addr=00000021");
      Req_Valid_i = 1'b1; Is_Store_i = 1'b1; Funct3_i = 3'd0; Address_i = 32'h21; Store_Data_i = 32'hAB;
      @(posedge clk); #1;
      chk("rmw_before_reset", {31'd0, Mem_Write_o}, 32'd1);
      reset = 1'b0;
      #1;
      chk("rmw_reset_write", {31'd0, Mem_Write_o}, 32'd0);
      reset = 1'b1;
      #1;
      chk("idle_after_reset_read", {31'd0, Mem_Read_o}, 32'd1);
      chk("idle_after_reset_stall", {31'd0, Stall_o}, 32'd1);
      Req_Valid_i = 1'b0;
      @(posedge clk); #1;
      chk("rmw_abandoned_word", tb_mem[8], 32'h1122_3344);

      do_op(1'b0, 3'd0, 32'h13, 32'h0);
      do_op(1'b0, 3'd4, 32'h13, 32'h0);
      do_op(1'b1, 3'd0, 32'h21, 32'hAB);
      do_op(1'b0, 3'd2, 32'h20, 32'h0);
      chk("sb_word", tb_mem[8], 32'h1122_AB44);
      do_op(1'b1, 3'd1, 32'h02, 32'hBEEF);
      do_op(1'b1, 3'd0, 32'h01, 32'h55);
      chk("sh_sb_word", tb_mem[0], 32'hBEEF_5500);
      do_op(1'b0, 3'd2, 32'h06, 32'h0);
      do_op(1'b1, 3'd1, 32'h03, 32'h1234);
      do_op(1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF);
      do_op(1'b0, 3'd5, 32'h42, 32'h0);
      chk("sw_word", tb_mem[16], 32'hDEAD_BEEF);

      for (int n = 0; n < 300; n++) begin
         st = 1'($urandom_range(0, 1));
         f3 = st ? st_f3[$urandom_range(0, 6)] : ld_f3[$urandom_range(0, 6)];
         do_op(st, f3, 32'($urandom_range(0, 1023)), $urandom);
      end

      bad = 0;
      for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
      chk("final_mem_mismatches", 32'(bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
